// File: rtl/nx_node_output_emit_pkg.sv
// Shared types for the node output emitter: message bundle and emit FSM states.
// Optional feature macro used by the emitter: NX_OUTPUT_FORCE_EN.
package nx_node_output_emit_pkg;

    localparam int NX_OUTPUTS   = 32;
    localparam int OUTPUT_IDX_W = $clog2(NX_OUTPUTS);

    typedef struct packed {
        logic [OUTPUT_IDX_W-1:0] index;
        logic                    value;
    } output_msg_t;

    typedef enum logic [1:0] {
        EMIT_IDLE,
        EMIT_LOAD,
        EMIT_SEND
    } emit_state_t;

endpackage

// File: rtl/nx_node_output_emit_lowest_set.sv
// nx_lowest_set: priority encoder returning the lowest set bit of a vector.
// Reusable; o_index is 0 when nothing is set.
module nx_lowest_set #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nx_node_output_emit.sv
// Snapshots core outputs on evaluation done and emits one {index,value}
// message per changed bit. Macro NX_OUTPUT_FORCE_EN: first capture emits all.
module nx_node_output_emit
    import nx_node_output_emit_pkg::*;
#(
    parameter int OUTPUTS = NX_OUTPUTS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [OUTPUTS-1:0] i_outputs,
    input  logic               i_core_idle,
    output output_msg_t        o_msg_data,
    output logic               o_msg_valid,
    input  logic               i_msg_ready,
    output logic               o_busy
);

    emit_state_t               r_state;
    emit_state_t               w_next;
    logic                      r_idle_q;
    logic                      r_retrig;
    logic [OUTPUTS-1:0]        r_snapshot;
    logic [OUTPUTS-1:0]        r_pending;
    logic [OUTPUTS-1:0]        r_last_sent;
    logic [OUTPUTS-1:0]        w_fresh;
    output_msg_t               r_msg;
    logic                      r_valid;
    logic                      w_done;
    logic                      w_capture;
    logic                      w_accept;
    logic                      w_found;
    logic [OUTPUT_IDX_W-1:0]   w_idx;
`ifdef NX_OUTPUT_FORCE_EN
    logic                      r_seeded;
`endif

    nx_lowest_set #(
        .WIDTH (OUTPUTS),
        .IDX_W (OUTPUT_IDX_W)
    ) u_lowest (
        .i_vec   (r_pending),
        .o_found (w_found),
        .o_index (w_idx)
    );

    assign w_done    = i_core_idle && !r_idle_q;
    assign w_capture = (r_state == EMIT_IDLE) && (w_done || r_retrig);
    assign w_accept  = (r_state == EMIT_SEND) && r_valid && i_msg_ready;

`ifdef NX_OUTPUT_FORCE_EN
    assign w_fresh = r_seeded ? (i_outputs ^ r_last_sent) : '1;
`else
    assign w_fresh = i_outputs ^ r_last_sent;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= EMIT_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMIT_IDLE: if (w_capture) w_next = EMIT_LOAD;
            EMIT_LOAD: w_next = w_found ? EMIT_SEND : EMIT_IDLE;
            EMIT_SEND: if (w_accept) w_next = EMIT_LOAD;
            default:   w_next = EMIT_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != EMIT_IDLE) || r_retrig;
        o_msg_valid = r_valid;
        o_msg_data  = r_msg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idle_q    <= 1'b1;
            r_retrig    <= 1'b0;
            r_snapshot  <= '0;
            r_pending   <= '0;
            r_last_sent <= '0;
            r_msg       <= '0;
            r_valid     <= 1'b0;
`ifdef NX_OUTPUT_FORCE_EN
            r_seeded    <= 1'b0;
`endif
        end else begin
            r_idle_q <= i_core_idle;
            if (w_capture) begin
                r_snapshot <= i_outputs;
                r_pending  <= w_fresh;
                r_retrig   <= 1'b0;
`ifdef NX_OUTPUT_FORCE_EN
                r_seeded   <= 1'b1;
`endif
            end else if (w_done && r_state != EMIT_IDLE) begin
                r_retrig <= 1'b1;
            end
            if (r_state == EMIT_LOAD && w_found) begin
                r_msg.index <= w_idx;
                r_msg.value <= r_snapshot[w_idx];
                r_valid     <= 1'b1;
            end
            // Capture and accept live in different states, never collide.
            if (w_accept) begin
                r_valid                  <= 1'b0;
                r_pending[r_msg.index]   <= 1'b0;
                r_last_sent[r_msg.index] <= r_snapshot[r_msg.index];
            end
        end
    end

endmodule

// File: tb/tb_nx_node_output_emit.sv
// Bench for nx_node_output_emit: vector table, hand sequences, random runs.
// Reference model works on whole-vector diffs and message queues.
module tb_nx_node_output_emit;
    import nx_node_output_emit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] outs;
    logic        idle;
    logic        ready;
    output_msg_t data;
    logic        valid;
    logic        busy;

    nx_node_output_emit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_outputs   (outs),
        .i_core_idle (idle),
        .o_msg_data  (data),
        .o_msg_valid (valid),
        .i_msg_ready (ready),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_last;
    bit          m_seeded;
    output_msg_t got_q[$];
    output_msg_t exp_q[$];

    typedef struct {
        logic [31:0] vec;
        int          n_msgs;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: messages for every differing bit, ascending, then update state.
    task automatic model_capture(input logic [31:0] v);
        logic [31:0] pend;
        pend = v ^ m_last;
`ifdef NX_OUTPUT_FORCE_EN
        if (!m_seeded) pend = '1;
`endif
        m_seeded = 1'b1;
        for (int i = 0; i < 32; i++)
            if (pend[i]) exp_q.push_back('{index: 5'(i), value: v[i]});
        m_last = v;
    endtask

    task automatic model_reset();
        m_last   = '0;
        m_seeded = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        idle  = 1'b1;
        ready = 1'b1;
        outs  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Leaves the caller in the done cycle T (idle just rose).
    task automatic pulse_done();
        @(negedge clk) idle = 1'b0;
        @(negedge clk) idle = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for valid", name);
        end
    endtask

    task automatic collect(input bit rnd, output int nbusy);
        bit          pv;
        bit          pr;
        output_msg_t pd;
        int          n;
        pv = 0; pr = 0; pd = '0; n = 0; nbusy = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                checks++;
                failures++;
                $display("FAIL collect_timeout busy=%0b required=0", busy);
                break;
            end
            if (busy) nbusy++;
            if (pv && !pr) begin
                chk("hold_valid", 32'(valid), 32'd1);
                chk("hold_data", 32'(data), 32'(pd));
            end
            ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (valid && ready) got_q.push_back(data);
            pv = valid; pr = ready; pd = data;
            if (!busy && !valid) break;
        end
    endtask

    task automatic compare_q(input string name);
        int n;
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({name, "_msg"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int nb;
        tbl[0] = '{32'h0000_0004, 1};
        tbl[1] = '{32'h0000_0004, 0};
        tbl[2] = '{32'hFFFF_0000, 17};
        tbl[3] = '{32'h0000_0000, 16};
        tbl[4] = '{32'h8000_0001, 2};

        // Reset state
        rst = 1'b1; idle = 1'b1; ready = 1'b1; outs = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        rst = 1'b0;
        model_reset();

        // Latency of the first message
        outs = 32'h0000_0005;
        pulse_done();
        model_capture(outs);
        @(negedge clk);
        chk("lat_t1_valid", 32'(valid), 32'd0);
        chk("lat_t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_t2_valid", 32'(valid), 32'd1);
        chk("lat_t2_data", 32'(data), 32'(exp_q[0]));
        got_q.push_back(data);
        collect(0, nb);
        compare_q("first");

        // Table: message count, busy length and content
        foreach (tbl[k]) begin
            outs = tbl[k].vec;
            pulse_done();
            model_capture(outs);
            collect(0, nb);
            chk("tbl_count", 32'(got_q.size()), 32'(tbl[k].n_msgs));
            chk("tbl_busy_cycles", 32'(nb), 32'(2 * tbl[k].n_msgs + 1));
            compare_q("tbl");
        end

        // Backpressure on the first message, then prompt follow-up
        do_reset();
        outs  = 32'h0000_0005;
        ready = 1'b0;
        pulse_done();
        model_capture(outs);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_data", 32'(exp_q[0]), 32'(data));
            @(negedge clk);
        end
        got_q.push_back(data);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_gap_valid", 32'(valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(valid), 32'd1);
        chk("bp_next_data", 32'(data), 32'(exp_q[1]));
        got_q.push_back(data);
        collect(0, nb);
        compare_q("bp");

        // Two dones mid-emit collapse into one retrigger with fresh outputs
        do_reset();
        outs = 32'h0000_0005;
        pulse_done();
        model_capture(32'h0000_0005);
        model_capture(32'h8000_0000);
        fork
            collect(1, nb);
            begin
                @(negedge clk);
                outs = 32'h8000_0000;
                pulse_done();
                pulse_done();
            end
        join
        compare_q("retrig");

        // Reset while a message is stalled
        do_reset();
        outs  = 32'h0000_0005;
        ready = 1'b0;
        pulse_done();
        model_capture(outs);
        wait_valid("rst_send");
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_send_valid", 32'(valid), 32'd0);
        chk("rst_send_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_reset();
        ready = 1'b1;
        pulse_done();
        model_capture(outs);
        collect(0, nb);
        compare_q("after_rst");

        // All-zero first capture: silent by default, full seed when forced
        do_reset();
        outs = '0;
        pulse_done();
        model_capture(outs);
        collect(1, nb);
        compare_q("zero_first");

        // Random vectors with random backpressure
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) != 0)
                outs = outs ^ ($urandom & $urandom & $urandom);
            pulse_done();
            model_capture(outs);
            collect(1, nb);
            compare_q("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
